// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolver: branch funct3 codes,
// 2-bit BHT counter encodings and their saturating update helpers.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The MSB of the counter is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  function automatic bht_state_e sat_inc(input bht_state_e s);
    return (s == ST) ? ST : bht_state_e'(s + 2'd1);
  endfunction

  function automatic bht_state_e sat_dec(input bht_state_e s);
    return (s == SNT) ? SNT : bht_state_e'(s - 2'd1);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator for the six RV64 conditional
// branches; funct3 010/011 are flagged illegal and never taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates the branch, trains a 2-bit-counter BHT,
// serves IF predictions, issues a registered redirect on mispredict and keeps
// saturating perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PC_W        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              illegal_branch,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             resolve;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             mispredict;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  bht_state_e       if_entry;
  bht_state_e       bht_next;

  bht_state_e       bht_q [BHT_ENTRIES];
  logic             redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]  redirect_pc_q,    redirect_pc_d;
  logic [PERF_W-1:0] perf_br_q,       perf_br_d;
  logic [PERF_W-1:0] perf_mp_q,       perf_mp_d;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign resolve        = ex_valid & ~ex_stall;
  assign ex_taken       = resolve & cmp_taken;
  assign illegal_branch = resolve & cmp_illegal;
  assign mispredict     = resolve & ~cmp_illegal & (ex_taken != ex_pred_taken);

  assign if_idx        = if_pc[IDX_W+1:2];
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign if_entry      = bht_q[if_idx];
  assign if_pred_taken = if_entry[1];
  assign bht_next      = ex_taken ? sat_inc(bht_q[ex_idx]) : sat_dec(bht_q[ex_idx]);

  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    perf_br_d        = perf_br_q;
    perf_mp_d        = perf_mp_q;
    if (mispredict) begin
      // Fall-through PC wraps modulo 2^PC_W.
      redirect_pc_d = ex_taken ? ex_target : ex_pc + PC_W'(4);
    end
    if (resolve && !(&perf_br_q)) perf_br_d = perf_br_q + PERF_W'(1);
    if (mispredict && !(&perf_mp_q)) perf_mp_d = perf_mp_q + PERF_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      perf_br_q        <= '0;
      perf_mp_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_br_q        <= perf_br_d;
      perf_mp_q        <= perf_mp_d;
    end
  end

  // NOTE: the BHT is a flop array, not a RAM, so every entry is reset
  // individually; this is what lets prediction start at weak-NT everywhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
    end else if (resolve && !cmp_illegal) begin
      bht_q[ex_idx] <= bht_next;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign perf_branches  = perf_br_q;
  assign perf_mispred   = perf_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; a second instance with
// narrow perf counters shares the stimulus to exercise counter saturation.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int PC_W  = 64;
  localparam int XLEN  = 64;
  localparam int SAT_W = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic              ex_valid, ex_stall;
  logic [2:0]        ex_funct3;
  logic [XLEN-1:0]   ex_rs1, ex_rs2;
  logic [PC_W-1:0]   ex_pc, ex_target;
  logic              ex_pred_taken;
  logic              ex_taken, illegal_branch, redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [31:0]       perf_branches, perf_mispred;

  logic              unused_pred, unused_taken, unused_ill, unused_rv;
  logic [PC_W-1:0]   unused_rpc;
  logic [SAT_W-1:0]  sat_branches, sat_mispred;

  int checks   = 0;
  int failures = 0;
  int exp_br   = 0;
  int exp_mp   = 0;
  logic [PC_W-1:0] exp_rpc = '0;

  always #5 clk = ~clk;

  branch_resolve_unit u_dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .illegal_branch(illegal_branch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  branch_resolve_unit #(.PERF_W(SAT_W)) u_sat (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_pred_taken(unused_pred),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_taken(unused_taken), .illegal_branch(unused_ill),
    .redirect_valid(unused_rv), .redirect_pc(unused_rpc),
    .perf_branches(sat_branches), .perf_mispred(sat_mispred)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_stall      = 1'b0;
    ex_funct3     = F3_BEQ;
    ex_rs1        = '0;
    ex_rs2        = '0;
    ex_pc         = '0;
    ex_target     = '0;
    ex_pred_taken = 1'b0;
  endtask

  // Drives one resolving branch, checks the combinational outcome, then the
  // registered redirect and perf counters one edge later.
  task automatic run_branch(input string tag, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                            input logic pred, input logic exp_t, input logic exp_ill);
    logic mp;
    ex_valid = 1'b1; ex_stall = 1'b0; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    #1;
    check({tag, "_taken"}, 64'(ex_taken), 64'(exp_t));
    check({tag, "_illegal"}, 64'(illegal_branch), 64'(exp_ill));
    mp = !exp_ill && (exp_t != pred);
    exp_br++;
    if (mp) begin
      exp_mp++;
      exp_rpc = exp_t ? tgt : pc + 64'd4;
    end
    step();
    idle();
    check({tag, "_rvalid"}, 64'(redirect_valid), 64'(mp));
    check({tag, "_rpc"}, redirect_pc, exp_rpc);
    check({tag, "_perf_br"}, 64'(perf_branches), 64'(exp_br));
    check({tag, "_perf_mp"}, 64'(perf_mispred), 64'(exp_mp));
  endtask

  initial begin
    idle();
    if_pc   = 64'h40;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_rvalid", 64'(redirect_valid), 64'd0);
    check("rst_rpc", redirect_pc, 64'd0);
    check("rst_perf_br", 64'(perf_branches), 64'd0);
    check("rst_perf_mp", 64'(perf_mispred), 64'd0);
    check("rst_pred", 64'(if_pred_taken), 64'd0);

    // beq taken, predicted NT: same-cycle lookup sees old 01, then 10.
    ex_valid = 1'b1; ex_funct3 = F3_BEQ; ex_rs1 = 64'd5; ex_rs2 = 64'd5;
    ex_pc = 64'h40; ex_target = 64'h800; ex_pred_taken = 1'b0;
    #1;
    check("beq_pred_pre", 64'(if_pred_taken), 64'd0);
    run_branch("beq", F3_BEQ, 64'd5, 64'd5, 64'h40, 64'h800, 1'b0, 1'b1, 1'b0);
    check("beq_rpc_target", redirect_pc, 64'h800);
    check("beq_pred_post", 64'(if_pred_taken), 64'd1);
    step();
    check("beq_rvalid_fall", 64'(redirect_valid), 64'd0);
    check("beq_rpc_hold", redirect_pc, 64'h800);

    // Signed vs unsigned with all-ones vs 1.
    run_branch("blt",  F3_BLT,  '1, 64'd1, 64'h204, 64'h300, 1'b1, 1'b1, 1'b0);
    run_branch("bltu", F3_BLTU, '1, 64'd1, 64'h204, 64'h300, 1'b0, 1'b0, 1'b0);
    run_branch("bge",  F3_BGE,  '1, 64'd1, 64'h204, 64'h300, 1'b0, 1'b0, 1'b0);
    run_branch("bgeu", F3_BGEU, '1, 64'd1, 64'h204, 64'h300, 1'b1, 1'b1, 1'b0);
    run_branch("bne_eq", F3_BNE, 64'd7, 64'd7, 64'h204, 64'h300, 1'b0, 1'b0, 1'b0);
    run_branch("bne_ne", F3_BNE, 64'd3, 64'd4, 64'h204, 64'h300, 1'b1, 1'b1, 1'b0);

    // Back-to-back mispredicts: two pulses, each with its own PC.
    run_branch("b2b_a", F3_BEQ, 64'd1, 64'd2, 64'h308, 64'h900, 1'b1, 1'b0, 1'b0);
    run_branch("b2b_b", F3_BNE, 64'd1, 64'd2, 64'h30C, 64'h500, 1'b0, 1'b1, 1'b0);
    step();
    check("b2b_fall", 64'(redirect_valid), 64'd0);

    // Saturation at 0x100: four taken -> 11, one NT -> 10, one more NT -> 01.
    if_pc = 64'h100;
    for (int i = 0; i < 4; i++)
      run_branch("sat_t", F3_BEQ, 64'd9, 64'd9, 64'h100, 64'h180, 1'b1, 1'b1, 1'b0);
    check("sat_st_pred", 64'(if_pred_taken), 64'd1);
    run_branch("sat_nt1", F3_BEQ, 64'd1, 64'd2, 64'h100, 64'h180, 1'b1, 1'b0, 1'b0);
    check("sat_wt_pred", 64'(if_pred_taken), 64'd1);
    run_branch("sat_nt2", F3_BEQ, 64'd1, 64'd2, 64'h100, 64'h180, 1'b0, 1'b0, 1'b0);
    check("sat_wnt_pred", 64'(if_pred_taken), 64'd0);

    // Stall and invalid: mispredicting taken branch on a fresh entry at 0x48.
    if_pc = 64'h48;
    ex_valid = 1'b1; ex_stall = 1'b1; ex_funct3 = F3_BEQ; ex_rs1 = 64'd5; ex_rs2 = 64'd5;
    ex_pc = 64'h48; ex_target = 64'hA00; ex_pred_taken = 1'b0;
    #1;
    check("stall_taken", 64'(ex_taken), 64'd0);
    step();
    ex_valid = 1'b0; ex_stall = 1'b0;
    #1;
    check("stall_rvalid", 64'(redirect_valid), 64'd0);
    check("stall_perf_br", 64'(perf_branches), 64'(exp_br));
    step();
    idle();
    check("nvalid_rvalid", 64'(redirect_valid), 64'd0);
    check("stall_pred", 64'(if_pred_taken), 64'd0);
    check("stall_rpc", redirect_pc, exp_rpc);

    // Illegal funct3: counted, but no training (else next taken would leave 01).
    run_branch("ill", 3'b010, 64'd5, 64'd5, 64'h48, 64'hA00, 1'b1, 1'b0, 1'b1);
    run_branch("ill_after", F3_BEQ, 64'd5, 64'd5, 64'h48, 64'hA00, 1'b1, 1'b1, 1'b0);
    check("ill_no_train", 64'(if_pred_taken), 64'd1);

    // Fall-through wraps to 0, then extra mispredicts to saturate u_sat.
    run_branch("wrap", F3_BNE, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b1, 1'b0, 1'b0);
    check("wrap_rpc_zero", redirect_pc, 64'd0);
    run_branch("mp_x1", F3_BGEU, 64'd0, 64'd1, 64'h10, 64'h20, 1'b1, 1'b0, 1'b0);
    run_branch("mp_x2", F3_BLT,  64'd0, 64'd1, 64'h10, 64'h20, 1'b0, 1'b1, 1'b0);
    run_branch("mp_x3", F3_BLT,  64'd0, 64'd1, 64'h10, 64'h24, 1'b0, 1'b1, 1'b0);
    check("sat_perf_br", 64'(sat_branches), 64'd7);
    check("sat_perf_mp", 64'(sat_mispred), 64'd7);

    // Reset the cycle after a mispredict: pulse drops immediately.
    ex_valid = 1'b1; ex_funct3 = F3_BEQ; ex_rs1 = 64'd1; ex_rs2 = 64'd1;
    ex_pc = 64'h48; ex_target = 64'hC00; ex_pred_taken = 1'b0;
    step();
    idle();
    check("pre_rst_rvalid", 64'(redirect_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst2_rvalid", 64'(redirect_valid), 64'd0);
    check("rst2_rpc", redirect_pc, 64'd0);
    check("rst2_perf_br", 64'(perf_branches), 64'd0);
    check("rst2_perf_mp", 64'(perf_mispred), 64'd0);
    check("rst2_pred_48", 64'(if_pred_taken), 64'd0);
    step();
    reset_n = 1'b1;
    exp_br = 0; exp_mp = 0; exp_rpc = '0;

    // Reset while a mispredict is presented: nothing emerges after release.
    ex_valid = 1'b1; ex_funct3 = F3_BNE; ex_rs1 = 64'd1; ex_rs2 = 64'd2;
    ex_pc = 64'h60; ex_target = 64'hD00; ex_pred_taken = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    idle();
    step();
    reset_n = 1'b1;
    step();
    check("cancel_rvalid", 64'(redirect_valid), 64'd0);

    // Entries restored to 01: one taken at 0x48 flips the prediction to 1.
    run_branch("post_rst", F3_BEQ, 64'd3, 64'd3, 64'h48, 64'hE00, 1'b1, 1'b1, 1'b0);
    check("post_rst_pred", 64'(if_pred_taken), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
